// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner tags
// and the deepest read latency the return pipe supports.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        CORE_PRI,
        HOST_PRI,
        HOST_LOCK
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_HOST
    } owner_t;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/dmem_rd_return.sv
// Read-return path: an owner-tag shift pipe matching the memory latency that
// steers mem_rdata to whichever side issued the read.
module dmem_rd_return
    import dmem_arb_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  owner_t        push_tag,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata
);

    localparam int DEPTH = (MEM_LAT < 1) ? 1 :
                           (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

    owner_t pipe_q [DEPTH];
    owner_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = push_tag;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Clearing the pipe drops any read in flight, so it never returns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= OWN_NONE;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign core_rvalid = (pipe_q[DEPTH-1] == OWN_CORE);
    assign host_rvalid = (pipe_q[DEPTH-1] == OWN_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter for a single-port data RAM with starvation relief and
// host lock. Optional stall/grant counters under DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stat_core_stall,
    output logic [31:0]   stat_host_grant
);

    localparam logic [7:0] STARVE_LIM8 = STARVE_LIMIT[7:0];

    arb_state_t state_q, state_d;
    logic [7:0] starve_q, starve_d;
    logic [7:0] starve_inc;
    owner_t     tag;

    always_comb begin
        core_gnt = 1'b0;
        host_gnt = 1'b0;
        if (reset_n) begin
            unique case (state_q)
                CORE_PRI: begin
                    core_gnt = core_req;
                    host_gnt = host_req & ~core_req;
                end
                HOST_PRI: begin
                    host_gnt = host_req;
                    core_gnt = core_req & ~host_req;
                end
                HOST_LOCK: host_gnt = host_req;
                default: ;
            endcase
        end
    end

    assign starve_inc = starve_q + 8'd1;

    // Counter only survives a cycle while the host keeps losing in CORE_PRI.
    always_comb begin
        state_d  = state_q;
        starve_d = 8'd0;
        if (host_gnt && host_lock) begin
            state_d = HOST_LOCK;
        end else begin
            unique case (state_q)
                CORE_PRI: begin
                    if (host_req && !host_gnt) begin
                        if (starve_inc == STARVE_LIM8) state_d = HOST_PRI;
                        else starve_d = starve_inc;
                    end
                end
                HOST_PRI:  state_d = CORE_PRI;
                HOST_LOCK: if (!host_lock) state_d = CORE_PRI;
                default:   state_d = CORE_PRI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= CORE_PRI;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    assign mem_en    = core_gnt | host_gnt;
    assign mem_we    = (core_gnt & core_we) | (host_gnt & host_we);
    assign mem_addr  = ({AW{core_gnt}} & core_addr) | ({AW{host_gnt}} & host_addr);
    assign mem_wdata = ({DW{core_gnt}} & core_wdata) | ({DW{host_gnt}} & host_wdata);

    always_comb begin
        tag = OWN_NONE;
        if (core_gnt && !core_we) tag = OWN_CORE;
        else if (host_gnt && !host_we) tag = OWN_HOST;
    end

    dmem_rd_return #(
        .DW      (DW),
        .MEM_LAT (MEM_LAT)
    ) u_rd_return (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_tag    (tag),
        .mem_rdata   (mem_rdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] hgnt_q, hgnt_d;

    always_comb begin
        stall_d = stall_q;
        hgnt_d  = hgnt_q;
        if (core_req && !core_gnt && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
        if (host_gnt && hgnt_q != 32'hFFFF_FFFF) hgnt_d = hgnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= 32'd0;
            hgnt_q  <= 32'd0;
        end else begin
            stall_q <= stall_d;
            hgnt_q  <= hgnt_d;
        end
    end

    assign stat_core_stall = stall_q;
    assign stat_host_grant = hgnt_q;
`else
    assign stat_core_stall = 32'd0;
    assign stat_host_grant = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          core_gnt, core_rvalid, host_gnt, host_rvalid;
    logic          mem_en, mem_we;
    logic [DW-1:0] core_rdata, host_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   stat_core_stall, stat_host_grant;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_core_stall(stat_core_stall), .stat_host_grant(stat_host_grant)
    );

    typedef struct {
        int due;
        int own;
    } ret_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_st = 0;
    int   m_starve = 0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_hgnt = 0;
    ret_t rq[$];
    logic e_cg = 1'b0, e_hg = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic settle();
        logic cv, hv;
        #1;
        e_cg = 1'b0;
        e_hg = 1'b0;
        if (reset_n) begin
            if (m_st == 0) begin
                e_cg = core_req;
                e_hg = host_req && !core_req;
            end else if (m_st == 1) begin
                e_hg = host_req;
                e_cg = core_req && !host_req;
            end else begin
                e_hg = host_req;
            end
        end
        cv = 1'b0;
        hv = 1'b0;
        if (reset_n && rq.size() > 0 && rq[0].due == cyc) begin
            cv = (rq[0].own == 1);
            hv = (rq[0].own == 2);
        end
        chk("core_gnt", 32'(core_gnt), 32'(e_cg));
        chk("host_gnt", 32'(host_gnt), 32'(e_hg));
        chk("mem_en", 32'(mem_en), 32'(e_cg || e_hg));
        chk("mem_we", 32'(mem_we), 32'((e_cg && core_we) || (e_hg && host_we)));
        chk("mem_addr", mem_addr, e_cg ? core_addr : e_hg ? host_addr : 32'd0);
        chk("mem_wdata", mem_wdata, e_cg ? core_wdata : e_hg ? host_wdata : 32'd0);
        chk("core_rvalid", 32'(core_rvalid), 32'(cv));
        chk("host_rvalid", 32'(host_rvalid), 32'(hv));
        chk("core_rdata", core_rdata, cv ? mem_rdata : 32'd0);
        chk("host_rdata", host_rdata, hv ? mem_rdata : 32'd0);
`ifdef DMEM_ARB_STATS_EN
        chk("stat_core_stall", stat_core_stall, m_stall);
        chk("stat_host_grant", stat_host_grant, m_hgnt);
`else
        chk("stat_core_stall", stat_core_stall, 32'd0);
        chk("stat_host_grant", stat_host_grant, 32'd0);
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        if (!reset_n) begin
            m_st = 0;
            m_starve = 0;
            m_stall = 0;
            m_hgnt = 0;
            rq.delete();
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            if (e_cg && !core_we) rq.push_back('{cyc + LAT, 1});
            else if (e_hg && !host_we) rq.push_back('{cyc + LAT, 2});
            if (core_req && !e_cg && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (e_hg && m_hgnt != 32'hFFFF_FFFF) m_hgnt++;
            if (e_hg && host_lock) begin
                m_st = 2;
                m_starve = 0;
            end else if (m_st == 2) begin
                if (!host_lock) m_st = 0;
                m_starve = 0;
            end else if (m_st == 1) begin
                m_st = 0;
                m_starve = 0;
            end else if (host_req && !e_hg) begin
                m_starve++;
                if (m_starve == LIM) begin
                    m_st = 1;
                    m_starve = 0;
                end
            end else begin
                m_starve = 0;
            end
        end
        cyc++;
        @(negedge clk);
        mem_rdata = $urandom;
    endtask

    task automatic set_core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        host_req = r; host_we = w; host_lock = l; host_addr = a; host_wdata = d;
    endtask

    task automatic idle(input int n);
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            settle();
            adv();
        end
    endtask

    int first_hg, n_hg, n_crv;

    initial begin
        @(negedge clk);
        settle();
        chk("rst_core_gnt", 32'(core_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        adv();
        settle();
        adv();
        reset_n = 1'b1;
        idle(2);

        // both request from CORE_PRI; core wins
        set_core(1, 0, 32'h64, 0);
        set_host(1, 0, 0, 32'h80, 0);
        settle();
        chk("both_core_gnt", 32'(core_gnt), 32'd1);
        chk("both_host_gnt", 32'(host_gnt), 32'd0);
        chk("both_addr", mem_addr, 32'h64);
        adv();
        set_core(0, 0, 0, 0);
        settle();
        chk("both_host_next", 32'(host_gnt), 32'd1);
        adv();
        set_host(0, 0, 0, 0, 0);
        settle();
        adv();
        mem_rdata = 32'h19;
        settle();
        chk("ret_core_rvalid", 32'(core_rvalid), 32'd1);
        chk("ret_core_rdata", core_rdata, 32'h19);
        chk("ret_host_rvalid", 32'(host_rvalid), 32'd0);
        adv();
        mem_rdata = 32'h2A;
        settle();
        chk("ret_host_rdata", host_rdata, 32'h2A);
        chk("ret_core_quiet", core_rdata, 32'd0);
        adv();
        idle(2);

        // starvation relief
        first_hg = 0;
        n_hg = 0;
        set_core(1, 1, 32'h200, 32'h1);
        set_host(1, 1, 0, 32'h300, 32'h2);
        for (int i = 1; i <= 20; i++) begin
            settle();
            if (host_gnt) begin
                n_hg++;
                if (first_hg == 0) first_hg = i;
            end
            if (i == 9) chk("starve_c9_core", 32'(core_gnt), 32'd0);
            if (i == 10) chk("starve_c10_core", 32'(core_gnt), 32'd1);
            adv();
        end
        chk("starve_first", first_hg, 32'd9);
        chk("starve_count", n_hg, 32'd2);
        idle(2);

        // lock
        set_host(1, 1, 1, 32'h10, 32'hA5);
        settle();
        chk("lock_hgnt", 32'(host_gnt), 32'd1);
        chk("lock_wdata", mem_wdata, 32'hA5);
        chk("lock_addr", mem_addr, 32'h10);
        adv();
        set_host(0, 0, 1, 0, 0);
        set_core(1, 1, 32'h44, 32'h5);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("lock_core_held", 32'(core_gnt), 32'd0);
            adv();
        end
        host_lock = 1'b0;
        settle();
        chk("unlock_same_cyc", 32'(core_gnt), 32'd0);
        adv();
        settle();
        chk("unlock_next", 32'(core_gnt), 32'd1);
        adv();
        idle(2);

        // latency 3, alternating owners
        for (int c = 0; c <= 6; c++) begin
            set_core(c == 0 || c == 2, 0, 32'h400 + c, 0);
            set_host(c == 1 || c == 3, 0, 0, 32'h500 + c, 0);
            mem_rdata = 32'h100 + c;
            settle();
            if (c >= 3) begin
                chk("lat_core_rv", 32'(core_rvalid), 32'((c - 3) % 2 == 0));
                chk("lat_host_rv", 32'(host_rvalid), 32'((c - 3) % 2 == 1));
                chk("lat_data", core_rdata | host_rdata, 32'h100 + c);
            end
            adv();
        end
        idle(2);

        // reset while a read is in flight
        set_core(1, 0, 32'h64, 0);
        set_host(1, 0, 0, 32'h80, 0);
        settle();
        adv();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_gnts", 32'({core_gnt, host_gnt, mem_en, mem_we}), 32'd0);
            chk("rst_rv", 32'({core_rvalid, host_rvalid}), 32'd0);
            chk("rst_addr", mem_addr, 32'd0);
            adv();
        end
        reset_n = 1'b1;
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0, 0);
        n_crv = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (core_rvalid) n_crv++;
            adv();
        end
        chk("rst_no_rvalid", n_crv, 32'd0);
        set_core(1, 1, 32'h8, 0);
        set_host(1, 1, 0, 32'hC, 0);
        settle();
        chk("rst_core_pri", 32'(core_gnt), 32'd1);
        adv();

        // stats: 3 host grants, 5 core stalls
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        set_host(1, 1, 1, 32'h20, 32'h1);
        set_core(0, 0, 0, 0);
        settle(); adv();
        set_core(1, 1, 32'h24, 32'h2);
        settle(); adv();
        settle(); adv();
        host_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle(); adv();
        end
        set_core(0, 0, 0, 0);
        set_host(0, 0, 0, 0, 0);
        settle(); adv();
        settle();
`ifdef DMEM_ARB_STATS_EN
        chk("stat_stall_lit", stat_core_stall, 32'd5);
        chk("stat_hgnt_lit", stat_host_grant, 32'd3);
`else
        chk("stat_stall_off", stat_core_stall, 32'd0);
        chk("stat_hgnt_off", stat_host_grant, 32'd0);
`endif
        adv();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            if (!(core_req && !e_cg)) begin
                set_core($urandom_range(0, 99) < 60, $urandom_range(0, 1), $urandom, $urandom);
            end
            if (!(host_req && !e_hg)) begin
                host_req   = $urandom_range(0, 99) < 50;
                host_we    = $urandom_range(0, 1);
                host_addr  = $urandom;
                host_wdata = $urandom;
            end
            if (m_st == 2) host_lock = ($urandom_range(0, 3) != 0);
            else host_lock = ($urandom_range(0, 9) == 0);
            settle();
            adv();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares one single-port data memory between the RV32I core's load/store port and an external host port (debug/DMA loader).
- Grants at most one access per cycle.
- Returns read data to the owner after a fixed memory latency.
- Core sees core_gnt=0 as a stall and must hold its request.
- Sits between the core's ALUResult/WriteData/MemWrite/ReadData interface and the data RAM; instruction fetch is outside its scope.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 1, memory read latency in cycles (1..4)
STARVE_LIMIT, 8, consecutive cycles a host request may be denied before host gets priority (1..255)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
core_req  in  1  core access request
core_we  in  1  1=store, 0=load
core_addr  in  AW  core byte address
core_wdata  in  DW  core store data
core_gnt  out  1  core access accepted this cycle (combinational)
core_rvalid  out  1  core read data valid
core_rdata  out  DW  core read data
host_req  in  1  host access request
host_we  in  1  1=write, 0=read
host_lock  in  1  host requests exclusive ownership
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host access accepted this cycle (combinational)
host_rvalid  out  1  host read data valid
host_rdata  out  DW  host read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en with mem_we=0
stat_core_stall  out  32  core stall-cycle count (optional feature)
stat_host_grant  out  32  host grant count (optional feature)

Behaviour:
- Reset (reset_n=0, async):
  - State CORE_PRI, starve counter 0, return pipe cleared.
  - All gnt/rvalid/mem_en/mem_we = 0; rdata outputs 0; stats 0.
  - Gnts are forced 0 while reset_n=0.
  - Reads in flight at reset are dropped; no rvalid is ever produced for them.
- Mux:
  - mem_en = core_gnt|host_gnt.
  - mem_we/addr/wdata come from the granted side; all are 0 when idle.
  - core_gnt and host_gnt are never both 1.
- FSM states: CORE_PRI, HOST_PRI, HOST_LOCK.
- CORE_PRI:
  - core_req wins; otherwise host_req is granted.
  - Starve counter increments each cycle host_req=1 and host_gnt=0, and clears on a host grant or when host_req=0.
  - When the counter reaches STARVE_LIMIT, the next state is HOST_PRI and the counter clears.
- HOST_PRI:
  - host_req wins; core is granted only if host_req=0.
  - After one host grant, or a cycle with host_req=0, the next state is CORE_PRI.
- HOST_LOCK:
  - Entered from any state when the host is granted with host_lock=1.
  - Only the host may be granted; core_gnt=0 even with host_req=0.
  - Exits to CORE_PRI in the cycle after host_lock is sampled 0.
  - Starve counter is held at 0 while in HOST_LOCK.
- Read return:
  - Each granted read pushes an owner tag into a MEM_LAT-deep shift pipe.
  - MEM_LAT cycles later, the matching rvalid pulses for 1 cycle with rdata=mem_rdata.
  - The non-owner's rdata is 0.
  - Writes push an empty tag.
  - Back-to-back reads are supported, one per cycle in flight.
- Writes complete in the grant cycle; there is no write response.
- Requests are not queued; a denied requester must hold req/we/addr/wdata until granted.

Optional Feature:
DMEM_ARB_STATS_EN
- Defined:
  - stat_core_stall increments each cycle core_req=1 and core_gnt=0.
  - stat_host_grant increments on each host_gnt.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {CORE_PRI, HOST_PRI, HOST_LOCK};
  - typedef enum owner_t {OWN_NONE, OWN_CORE, OWN_HOST} (2-bit);
  - MEM_LAT_MAX=4.
- Sub-module dmem_rd_return: the MEM_LAT-stage owner_t shift pipe plus rvalid/rdata demux.

Test Plan:
- Both requests, lock free: core_req=1 (load 0x64) and host_req=1 (read 0x80) together from CORE_PRI -> core_gnt=1, host_gnt=0. With MEM_LAT=1, core_rvalid=1 the next cycle, core_rdata=mem_rdata=0x19, host_rvalid=0.
- Host starvation: core_req held high for 20 cycles with host_req=1, STARVE_LIMIT=8 -> first host_gnt on cycle 9; core_gnt=0 that cycle; core wins again on cycle 10.
- Lock: host writes 0xA5 to 0x10 with host_lock=1, then 3 idle cycles, with core_req=1 throughout -> core_gnt=0 for all 4 cycles. host_lock=0 sampled -> core_gnt=1 the following cycle.
- Latency 3: MEM_LAT=3, alternating core/host reads on 4 consecutive cycles -> rvalid pulses arrive on cycles 3..6 in the same owner order with matching data.
- Reset mid-read: MEM_LAT=2, core read granted, reset_n=0 the next cycle -> no core_rvalid ever; all outputs 0 during reset; state CORE_PRI after release.
- Stats (DMEM_ARB_STATS_EN): 5 core stall cycles and 3 host grants -> stat_core_stall=5, stat_host_grant=3. Without the macro, both read 0.
